// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    // A neuron is REFRACTORY exactly while its refractory counter is non-zero.
    typedef enum logic {
        ACTIVE     = 1'b0,
        REFRACTORY = 1'b1
    } neuron_state_e;

    localparam int CNT_WIDTH = 16;

    // Clamp a signed sum into the unsigned membrane range [0, v_max].
    function automatic int sat_clamp(input int sum, input int v_max);
        if (sum < 0) begin
            return 0;
        end
        if (sum > v_max) begin
            return v_max;
        end
        return sum;
    endfunction

    // Unsigned potential plus a sign-extended weight, saturated to [0, v_max].
    function automatic int sat_add(input int v, input int w, input int v_max);
        return sat_clamp(v + w, v_max);
    endfunction

    // Number of set bits in a vector of up to 32 bits (zero-extend narrower vectors).
    function automatic int popcount(input logic [31:0] vec);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lif_neuron_cell.sv
// One leaky integrate-and-fire neuron: membrane potential, refractory counter,
// accumulate / leak / threshold-compare logic and a combinational fire strobe.
module lif_neuron_cell
    import lif_pkg::*;
#(
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      acc_i,      // weighted spike addressed to this neuron
    input  logic signed [W_WIDTH-1:0] wspike_i,
    input  logic                      tick_i,
    input  logic [15:0]               rec_add_i,  // recurrent contribution, already gated by i_recc
    input  logic [V_WIDTH-1:0]        thres_i,
    output logic [V_WIDTH-1:0]        v_o,
    output logic                      spike_o     // fires on the tick edge that samples it
);

    // Keep a 1-bit counter when refractory is disabled so widths stay legal.
    localparam int R_WIDTH = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int V_MAX   = (1 << V_WIDTH) - 1;

    logic [V_WIDTH-1:0] v_q, v_d;
    logic [R_WIDTH-1:0] refr_q, refr_d;
    neuron_state_e      state;
    int                 in_w;
    int                 a_sum;
    int                 leaked;

    assign state = (refr_q != '0) ? REFRACTORY : ACTIVE;
    assign v_o   = v_q;

    // Next-state logic: accumulate between ticks, integrate/leak/fire on a tick.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        v_d     = v_q;
        refr_d  = refr_q;
        spike_o = 1'b0;
        // Input to a refractory neuron is dropped.
        in_w    = (acc_i && state == ACTIVE) ? int'(wspike_i) : 0;
        // Single saturation over potential, same-cycle input and recurrent feedback.
        a_sum   = sat_add(int'(v_q), in_w + (tick_i ? int'(rec_add_i) : 0), V_MAX);
        leaked  = a_sum - (a_sum >>> LEAK_SHIFT);

        if (tick_i) begin
            if (state == REFRACTORY) begin
                refr_d = refr_q - R_WIDTH'(1);
                v_d    = '0;
            end else if (leaked >= int'(thres_i)) begin
                spike_o = 1'b1;
                v_d     = '0;
                refr_d  = R_WIDTH'(REFRAC);
            end else begin
                v_d = V_WIDTH'(leaked);
            end
        end else if (state == ACTIVE && acc_i) begin
            v_d = V_WIDTH'(a_sum);
        end
    end

    // Potential and refractory state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            refr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            v_q    <= v_d;
            refr_q <= refr_d;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons sharing one weighted-spike bus,
// one programmable threshold and one timestep strobe, with optional recurrence.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int THRES_INIT = 32,
    parameter int REC_WEIGHT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_svalid,
    input  logic [$clog2(N_NEURONS)-1:0] i_nid,
    input  logic [W_WIDTH-1:0]           i_wspike,
    input  logic                         i_tick,
    input  logic                         i_recc,
    input  logic                         i_Thres_valid,
    input  logic [V_WIDTH-1:0]           i_Thres,
    output logic [V_WIDTH-1:0]           o_V,
    output logic [N_NEURONS-1:0]         o_spike,
    output logic                         o_spike_valid,
    output logic [CNT_WIDTH-1:0]         o_spike_cnt
);

    logic [V_WIDTH-1:0]   thres_q;
    logic [V_WIDTH-1:0]   v_all [N_NEURONS];
    logic [N_NEURONS-1:0] acc_sel;
    logic [N_NEURONS-1:0] spike_now;
    logic [N_NEURONS-1:0] spike_q;
    logic                 spike_valid_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [V_WIDTH-1:0]   v_sel;
    logic [V_WIDTH-1:0]   o_v_q;
    logic [15:0]          rec_add;

    // Recurrent drive from the spike vector registered before this edge.
    always_comb begin
        rec_add = i_recc ? 16'(REC_WEIGHT * popcount(32'(spike_q))) : '0;
    end

    // Potential of the addressed neuron; out-of-range ids read as zero.
    always_comb begin
        v_sel = '0;
        if (int'(i_nid) < N_NEURONS) begin
            v_sel = v_all[i_nid];
        end
    end

    // Spike counter increment with headroom bit for saturation.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(popcount(32'(spike_now)));
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
        assign acc_sel[g] = i_svalid && (int'(i_nid) == g);

        lif_neuron_cell #(
            .V_WIDTH   (V_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .LEAK_SHIFT(LEAK_SHIFT),
            .REFRAC    (REFRAC)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .acc_i    (acc_sel[g]),
            .wspike_i (i_wspike),
            .tick_i   (i_tick),
            .rec_add_i(rec_add),
            .thres_i  (thres_q),
            .v_o      (v_all[g]),
            .spike_o  (spike_now[g])
        );
    end

    // Threshold, output spike vector, spike counter and potential readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thres_q       <= V_WIDTH'(THRES_INIT);
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            cnt_q         <= '0;
            o_v_q         <= '0;
        end else begin
            o_v_q         <= v_sel;
            spike_valid_q <= i_tick;
            if (i_Thres_valid) begin
                thres_q <= i_Thres;
            end
            if (i_tick) begin
                spike_q <= spike_now;
                cnt_q   <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign o_V           = o_v_q;
    assign o_spike       = spike_q;
    assign o_spike_valid = spike_valid_q;
    assign o_spike_cnt   = cnt_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array with default parameters.
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_svalid = 1'b0;
    logic [1:0]  i_nid = '0;
    logic [3:0]  i_wspike = '0;
    logic        i_tick = 1'b0;
    logic        i_recc = 1'b0;
    logic        i_Thres_valid = 1'b0;
    logic [7:0]  i_Thres = '0;
    logic [7:0]  o_V;
    logic [3:0]  o_spike;
    logic        o_spike_valid;
    logic [15:0] o_spike_cnt;

    int checks = 0;
    int errors = 0;

    lif_neuron_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_svalid     (i_svalid),
        .i_nid        (i_nid),
        .i_wspike     (i_wspike),
        .i_tick       (i_tick),
        .i_recc       (i_recc),
        .i_Thres_valid(i_Thres_valid),
        .i_Thres      (i_Thres),
        .o_V          (o_V),
        .o_spike      (o_spike),
        .o_spike_valid(o_spike_valid),
        .o_spike_cnt  (o_spike_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic spike_in(input logic [1:0] nid, input logic [3:0] w);
        i_svalid = 1'b1;
        i_nid    = nid;
        i_wspike = w;
        cyc();
        i_svalid = 1'b0;
        i_wspike = '0;
    endtask

    task automatic do_tick(input logic recc);
        i_tick = 1'b1;
        i_recc = recc;
        cyc();
        i_tick = 1'b0;
        i_recc = 1'b0;
    endtask

    task automatic load_thres(input logic [7:0] t);
        i_Thres_valid = 1'b1;
        i_Thres       = t;
        cyc();
        i_Thres_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic read_v(input logic [1:0] nid, input logic [7:0] exp, input string tag);
        i_nid = nid;
        cyc();
        cyc();
        check(tag, 32'(o_V), 32'(exp));
    endtask

    initial begin
        // Reset values
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("reset_o_V", 32'(o_V), 0);
        check("reset_o_spike", 32'(o_spike), 0);
        check("reset_o_spike_valid", 32'(o_spike_valid), 0);
        check("reset_o_spike_cnt", 32'(o_spike_cnt), 0);

        // Accumulate and leak: 5 x 7 = 35, tick -> 35 - 4 = 31 < 32
        repeat (5) spike_in(2'd1, 4'h7);
        read_v(2'd1, 8'd35, "acc_v1_35");
        do_tick(1'b0);
        check("leak_no_spike", 32'(o_spike), 0);
        check("tick_valid_pulse", 32'(o_spike_valid), 1);
        cyc();
        check("tick_valid_clears", 32'(o_spike_valid), 0);
        read_v(2'd1, 8'd31, "leak_v1_31");
        check("leak_cnt_0", 32'(o_spike_cnt), 0);

        // Threshold load 20: 4 x 7 = 28, tick -> 25 >= 20 fires
        do_reset();
        load_thres(8'd20);
        repeat (4) spike_in(2'd1, 4'h7);
        do_tick(1'b0);
        check("thres_spike_vec", 32'(o_spike), 32'h2);
        check("thres_spike_valid", 32'(o_spike_valid), 1);
        check("thres_cnt_1", 32'(o_spike_cnt), 1);
        read_v(2'd1, 8'd0, "thres_v1_cleared");

        // Refractory drop plus recurrent feedback (o_spike = 0010)
        spike_in(2'd1, 4'h7);
        spike_in(2'd0, 4'h7);
        spike_in(2'd0, 4'h3);
        read_v(2'd1, 8'd0, "refr_drop_1");
        read_v(2'd0, 8'd10, "rec_v0_pre");
        do_tick(1'b1);
        check("rec_tick_no_spike", 32'(o_spike), 0);
        read_v(2'd0, 8'd13, "rec_on_v0_13");
        read_v(2'd2, 8'd4, "rec_on_v2_4");
        spike_in(2'd1, 4'h7);
        read_v(2'd1, 8'd0, "refr_drop_2");
        do_tick(1'b0);
        spike_in(2'd1, 4'h7);
        read_v(2'd1, 8'd7, "refr_done_v1_7");

        // Second spike of neuron 1, then a tick with recurrence disabled
        repeat (3) spike_in(2'd1, 4'h7);
        do_tick(1'b0);
        check("spike2_vec", 32'(o_spike), 32'h2);
        check("spike2_cnt_2", 32'(o_spike_cnt), 2);
        spike_in(2'd0, 4'hF);
        read_v(2'd0, 8'd10, "rec_off_v0_pre");
        do_tick(1'b0);
        read_v(2'd0, 8'd9, "rec_off_v0_9");

        // Reset while neuron 1 is still refractory
        do_reset();
        check("midreset_o_spike", 32'(o_spike), 0);
        check("midreset_valid", 32'(o_spike_valid), 0);
        check("midreset_cnt", 32'(o_spike_cnt), 0);
        read_v(2'd0, 8'd0, "midreset_v0");
        spike_in(2'd1, 4'h7);
        read_v(2'd1, 8'd7, "midreset_v1_accepts");
        repeat (4) spike_in(2'd1, 4'h7);
        do_tick(1'b0);
        check("midreset_thres_32", 32'(o_spike), 0);

        // Tick in the load cycle compares against the old threshold: 38 -> 34 >= 32
        spike_in(2'd1, 4'h7);
        i_Thres_valid = 1'b1;
        i_Thres       = 8'd40;
        i_tick        = 1'b1;
        cyc();
        i_Thres_valid = 1'b0;
        i_tick        = 1'b0;
        check("load_cycle_old_thres", 32'(o_spike), 32'h2);

        // Saturation at both ends, and l == threshold fires
        do_reset();
        repeat (35) spike_in(2'd2, 4'h7);
        spike_in(2'd2, 4'h5);
        read_v(2'd2, 8'd250, "sat_v2_250");
        spike_in(2'd2, 4'h7);
        read_v(2'd2, 8'd255, "sat_high_255");
        spike_in(2'd3, 4'h3);
        spike_in(2'd3, 4'h8);
        read_v(2'd3, 8'd0, "sat_low_0");
        repeat (5) spike_in(2'd0, 4'h7);
        spike_in(2'd0, 4'h1);
        do_tick(1'b0);
        check("thres_equal_fires", 32'(o_spike), 32'h5);
        check("thres_equal_cnt", 32'(o_spike_cnt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
